dmem_responder: RTL

//   Responder end of the pipeline's memory-stage data interface: accepts load/store requests
//   (address = ALUOutM, store data = WriteDataM), services them from an on-chip word RAM after
//   a programmable number of wait states, and returns ReadDataM.

---
 rtl/dmem_pkg.sv | 43 ++++
 rtl/dmem_if.sv | 37 +++
 rtl/dmem_ram.sv | 27 ++
 rtl/dmem_responder.sv | 138 +++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the memory-stage data responder.
package dmem_pkg;

  localparam int unsigned CntWidth = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic [1:0] Lane0 = 2'd0;
  localparam logic [1:0] Lane1 = 2'd1;
  localparam logic [1:0] Lane2 = 2'd2;
  localparam logic [1:0] Lane3 = 2'd3;

  function automatic logic [3:0] lane_be(input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    unique case (lane)
      Lane0: be = 4'b0001;
      Lane1: be = 4'b0010;
      Lane2: be = 4'b0100;
      Lane3: be = 4'b1000;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    b = 8'h00;
    unique case (lane)
      Lane0: b = word[7:0];
      Lane1: b = word[15:8];
      Lane2: b = word[23:16];
      Lane3: b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Memory-stage data bus between the pipeline (master) and the responder (slave).
// DMEM_BYTE_ACCESS_EN adds the ByteM sideband.
interface dmem_if;

  logic        ReqM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
`ifdef DMEM_BYTE_ACCESS_EN
  logic        ByteM;
`endif
  logic [31:0] ReadDataM;
  logic        ReadyM;
  logic        ErrM;
  logic        StallM;

`ifdef DMEM_BYTE_ACCESS_EN
  modport master (
    output ReqM, MemWriteM, ALUOutM, WriteDataM, ByteM,
    input  ReadDataM, ReadyM, ErrM, StallM
  );
  modport slave (
    input  ReqM, MemWriteM, ALUOutM, WriteDataM, ByteM,
    output ReadDataM, ReadyM, ErrM, StallM
  );
`else
  modport master (
    output ReqM, MemWriteM, ALUOutM, WriteDataM,
    input  ReadDataM, ReadyM, ErrM, StallM
  );
  modport slave (
    input  ReqM, MemWriteM, ALUOutM, WriteDataM,
    output ReadDataM, ReadyM, ErrM, StallM
  );
`endif

endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables; contents are never cleared.
// Writes are clocked; the read is combinational so the caller can capture it on the same edge.
module dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 64,
  localparam int unsigned AddrWidth = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [3:0]           be,
  input  logic [AddrWidth-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data responder: word RAM behind an IDLE/WAIT/RESP handshake with wait states.
// Defining DMEM_BYTE_ACCESS_EN enables byte loads/stores selected by ByteM.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);

  localparam int unsigned AddrWidth = $clog2(DEPTH_WORDS);
  localparam logic [CntWidth-1:0] CntInit =
      (WAIT_STATES == 0) ? '0 : CntWidth'(WAIT_STATES - 1);
  localparam logic [31:0] AddrLimit = 32'(4 * DEPTH_WORDS);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                we_q, byte_q, err_q;
  logic [31:0]         addr_q, wdata_q, rdata_q;

  logic        req_byte, accept, exec;
  logic        ex_we, ex_byte, ex_err;
  logic [31:0] ex_addr, ex_wdata;
  logic [1:0]  ex_lane;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata, load_data;

`ifdef DMEM_BYTE_ACCESS_EN
  assign req_byte = bus.ByteM;
`else
  assign req_byte = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    exec    = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.ReqM) begin
          accept = 1'b1;
          cnt_d  = CntInit;
          if (WAIT_STATES == 0) begin
            exec    = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          exec    = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // ReqM here still belongs to the completing access, so it is not re-accepted.
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states the access executes on the accept edge, straight from the bus.
  always_comb begin
    if (state_q == StIdle) begin
      ex_we    = bus.MemWriteM;
      ex_addr  = bus.ALUOutM;
      ex_wdata = bus.WriteDataM;
      ex_byte  = req_byte;
    end else begin
      ex_we    = we_q;
      ex_addr  = addr_q;
      ex_wdata = wdata_q;
      ex_byte  = byte_q;
    end
  end

  assign ex_lane   = ex_addr[1:0];
  assign ex_err    = (ex_addr >= AddrLimit) || (!ex_byte && (ex_lane != 2'b00));
  assign ram_we    = exec && ex_we && !ex_err;
  assign ram_be    = ex_byte ? lane_be(ex_lane) : 4'b1111;
  assign ram_wdata = ex_byte ? {4{ex_wdata[7:0]}} : ex_wdata;
  assign load_data = ex_byte ? {24'h000000, lane_byte(ram_rdata, ex_lane)} : ram_rdata;

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (ram_be),
    .addr (ex_addr[AddrWidth+1:2]),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.MemWriteM;
        addr_q  <= bus.ALUOutM;
        wdata_q <= bus.WriteDataM;
        byte_q  <= req_byte;
      end
      if (exec) begin
        err_q <= ex_err;
        if (ex_err) begin
          rdata_q <= '0;
        end else if (!ex_we) begin
          rdata_q <= load_data;
        end
      end
    end
  end

  assign bus.ReadDataM = rdata_q;
  assign bus.ReadyM    = (state_q == StResp);
  assign bus.ErrM      = (state_q == StResp) && err_q;
  assign bus.StallM    = ((state_q == StIdle) && bus.ReqM) || (state_q == StWait);

endmodule
